// File: rtl/mod_74x867_if.sv
// rtl/mod_74x867_if.sv - control/data bundle of the 74x867-style 8-bit up/down counter
//
// Signals:
//   S      [1:0]  mode select (00 sync clear, 01 down, 10 load, 11 up)
//   D      [7:0]  parallel load data
//   ENP_N         count enable P, active-low
//   ENT_N         count enable T, active-low, also gates RCO_N
//   OE_N          output enable, active-low (only with MOD_74X867_OE_EN)
//   Q      [7:0]  counter value
//   RCO_N         ripple carry out, active-low
// Modports: master drives controls and reads results, slave is the counter.
interface mod_74x867_if;
  logic [1:0] S;
  logic [7:0] D;
  logic       ENP_N;
  logic       ENT_N;
`ifdef MOD_74X867_OE_EN
  logic       OE_N;
`endif
  logic [7:0] Q;
  logic       RCO_N;

`ifdef MOD_74X867_OE_EN
  modport master (output S, output D, output ENP_N, output ENT_N, output OE_N,
                  input Q, input RCO_N);
  modport slave  (input S, input D, input ENP_N, input ENT_N, input OE_N,
                  output Q, output RCO_N);
`else
  modport master (output S, output D, output ENP_N, output ENT_N,
                  input Q, input RCO_N);
  modport slave  (input S, input D, input ENP_N, input ENT_N,
                  output Q, output RCO_N);
`endif
endinterface

// File: rtl/mod_74x867.sv
// rtl/mod_74x867.sv - synchronous 8-bit up/down binary counter modelled on the 74x867
//
// Ports:
//   CLK   counter clock, rising edge
//   CLR   asynchronous clear, active-high, priority over everything
//   bus   mod_74x867_if.slave (S, D, ENP_N, ENT_N, [OE_N], Q, RCO_N)
// Optional feature macro: MOD_74X867_OE_EN adds OE_N; OE_N = 1 floats Q
// while counting, load, clear and RCO_N carry on unaffected.
// Cascade: stage N RCO_N -> stage N+1 ENT_N, S and ENP_N tied in common.
module mod_74x867 (
  input  logic        CLK,
  input  logic        CLR,
  mod_74x867_if.slave bus
);

  logic [7:0] count;
  logic       cnt_en;

  // Both enables must be asserted (low) to step; load and sync clear ignore them.
  assign cnt_en = ~bus.ENP_N & ~bus.ENT_N;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      count <= 8'h00;
    end else begin
      case (bus.S)
        2'b00: count <= 8'h00;
        2'b01: if (cnt_en) count <= count - 8'd1;
        2'b10: count <= bus.D;
        2'b11: if (cnt_en) count <= count + 8'd1;
        default: count <= count;
      endcase
    end
  end

  // Terminal count depends on direction: FF going up, 00 going down.
  // ENP_N is deliberately absent so a cascade's upper stage sees a clean carry.
  assign bus.RCO_N = ~(~bus.ENT_N &
                       (((bus.S == 2'b11) && (count == 8'hFF)) ||
                        ((bus.S == 2'b01) && (count == 8'h00))));

`ifdef MOD_74X867_OE_EN
  assign bus.Q = bus.OE_N ? 8'hzz : count;
`else
  assign bus.Q = count;
`endif

endmodule

// File: tb/tb_mod_74x867.sv
// tb/tb_mod_74x867.sv - self-checking bench for mod_74x867 with a behavioural model
module tb_mod_74x867;

  logic CLK;
  logic CLR;

  mod_74x867_if bus ();
  mod_74x867_if lo_bus ();
  mod_74x867_if hi_bus ();

  mod_74x867 dut    (.CLK(CLK), .CLR(CLR), .bus(bus));
  mod_74x867 dut_lo (.CLK(CLK), .CLR(CLR), .bus(lo_bus));
  mod_74x867 dut_hi (.CLK(CLK), .CLR(CLR), .bus(hi_bus));

  assign hi_bus.ENT_N = lo_bus.RCO_N;

  int n_checks = 0;
  int n_pass   = 0;
  int m        = 0;  // model count value, 0..255

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic model_rco(input logic [1:0] s, input logic ent_n, input int c);
    if (ent_n == 1'b0 && ((s == 2'b11 && c == 255) || (s == 2'b01 && c == 0)))
      return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input logic [1:0] s, input logic [7:0] d, input logic enp_n, input logic ent_n);
    bus.S = s;
    bus.D = d;
    bus.ENP_N = enp_n;
    bus.ENT_N = ent_n;
  endtask

  // One rising edge: step the model from the sampled inputs, then compare.
  task automatic tick(input string tag);
    @(posedge CLK);
    if (CLR) m = 0;
    else begin
      case (bus.S)
        2'b00: m = 0;
        2'b10: m = int'(bus.D);
        2'b11: if (!bus.ENP_N && !bus.ENT_N) m = (m + 1) % 256;
        default: if (!bus.ENP_N && !bus.ENT_N) m = (m + 255) % 256;
      endcase
    end
    #1;
`ifdef MOD_74X867_OE_EN
    if (bus.OE_N) check({tag, ".q"}, {8'h00, bus.Q}, 16'h00zz);
    else          check({tag, ".q"}, {8'h00, bus.Q}, 16'(m));
`else
    check({tag, ".q"}, {8'h00, bus.Q}, 16'(m));
`endif
    check({tag, ".rco"}, {15'h0, bus.RCO_N}, {15'h0, model_rco(bus.S, bus.ENT_N, m)});
  endtask

  initial begin
    CLR = 1'b1;
`ifdef MOD_74X867_OE_EN
    bus.OE_N = 1'b0;
    lo_bus.OE_N = 1'b0;
    hi_bus.OE_N = 1'b0;
`endif
    lo_bus.S = 2'b00; lo_bus.D = 8'h00; lo_bus.ENP_N = 1'b1; lo_bus.ENT_N = 1'b1;
    hi_bus.S = 2'b00; hi_bus.D = 8'h00; hi_bus.ENP_N = 1'b1;
    drive(2'b11, 8'h5A, 1'b0, 1'b0);

    // Reset state
    #2;
    check("rst.q", {8'h00, bus.Q}, 16'h0000);
    check("rst.rco", {15'h0, bus.RCO_N}, 16'h0001);
    @(posedge CLK); #1;
    check("rst.hold_q", {8'h00, bus.Q}, 16'h0000);
    @(negedge CLK);
    CLR = 1'b0;
    m = 0;
    tick("rst_rel");
    check("rst_rel.one", {8'h00, bus.Q}, 16'h0001);

    // Up wrap
    @(negedge CLK); drive(2'b10, 8'hFE, 1'b1, 1'b1); tick("up.load");
    @(negedge CLK); drive(2'b11, 8'h00, 1'b0, 1'b0); tick("up.ff");
    check("up.ff_rco", {7'h0, bus.RCO_N, bus.Q}, 16'h00FF);
    tick("up.wrap");
    check("up.wrap_q", {7'h0, bus.RCO_N, bus.Q}, 16'h0100);
    for (int i = 0; i < 256; i++) tick("up.loop");
    check("up.256", {8'h00, bus.Q}, 16'h0000);

    // Down wrap
    @(negedge CLK); drive(2'b10, 8'h01, 1'b0, 1'b0); tick("dn.load");
    @(negedge CLK); drive(2'b01, 8'h00, 1'b0, 1'b0); tick("dn.zero");
    check("dn.zero_q", {7'h0, bus.RCO_N, bus.Q}, 16'h0000);
    tick("dn.wrap");
    check("dn.wrap_q", {7'h0, bus.RCO_N, bus.Q}, 16'h01FF);

    // Enable gating at FF counting up
    @(negedge CLK); drive(2'b10, 8'hFF, 1'b0, 1'b0); tick("en.load");
    @(negedge CLK); drive(2'b11, 8'h00, 1'b1, 1'b0); tick("en.enp");
    check("en.enp_q", {7'h0, bus.RCO_N, bus.Q}, 16'h00FF);
    @(negedge CLK); drive(2'b11, 8'h00, 1'b0, 1'b1); tick("en.ent");
    check("en.ent_q", {7'h0, bus.RCO_N, bus.Q}, 16'h01FF);
    @(negedge CLK); drive(2'b10, 8'hA5, 1'b0, 1'b1); tick("en.ld");
    check("en.ld_q", {8'h00, bus.Q}, 16'h00A5);

    // Async clear mid-count
    @(negedge CLK); drive(2'b10, 8'h36, 1'b0, 1'b0); tick("ac.load");
    @(negedge CLK); drive(2'b11, 8'h00, 1'b0, 1'b0); tick("ac.37");
    check("ac.37_q", {8'h00, bus.Q}, 16'h0037);
    #2; CLR = 1'b1; #1;
    check("ac.clr_q", {8'h00, bus.Q}, 16'h0000);
    m = 0;
    #1; CLR = 1'b0;
    tick("ac.rel");
    check("ac.rel_q", {8'h00, bus.Q}, 16'h0001);

    // Randomized traffic with occasional async clear pulses
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      drive(2'($urandom_range(0, 3)), 8'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
`ifdef MOD_74X867_OE_EN
      bus.OE_N = ($urandom_range(0, 7) == 0);
`endif
      if ($urandom_range(0, 15) == 0) begin
        CLR = 1'b1; #1;
        m = 0;
`ifdef MOD_74X867_OE_EN
        if (!bus.OE_N) check("rnd.clr", {8'h00, bus.Q}, 16'h0000);
`else
        check("rnd.clr", {8'h00, bus.Q}, 16'h0000);
`endif
        check("rnd.clr_rco", {15'h0, bus.RCO_N}, {15'h0, model_rco(bus.S, bus.ENT_N, 0)});
        #1; CLR = 1'b0;
      end
      tick("rnd");
    end

    // Cascade of two stages
    @(negedge CLK);
    lo_bus.S = 2'b10; lo_bus.D = 8'hFE; hi_bus.S = 2'b10; hi_bus.D = 8'h00;
    @(posedge CLK); #1;
    check("cas.load", {hi_bus.Q, lo_bus.Q}, 16'h00FE);
    @(negedge CLK);
    lo_bus.S = 2'b11; hi_bus.S = 2'b11; lo_bus.ENP_N = 1'b0; hi_bus.ENP_N = 1'b0; lo_bus.ENT_N = 1'b0;
    @(posedge CLK); #1;
    check("cas.e1", {hi_bus.Q, lo_bus.Q}, 16'h00FF);
`ifdef MOD_74X867_OE_EN
    @(negedge CLK); lo_bus.OE_N = 1'b1; hi_bus.OE_N = 1'b1;
    @(posedge CLK); #1;
    check("cas.hiz", {hi_bus.Q, lo_bus.Q}, 16'hzzzz);
    @(negedge CLK); lo_bus.OE_N = 1'b0; hi_bus.OE_N = 1'b0; #1;
    check("cas.e2", {hi_bus.Q, lo_bus.Q}, 16'h0100);
`else
    @(posedge CLK); #1;
    check("cas.e2", {hi_bus.Q, lo_bus.Q}, 16'h0100);
`endif
    @(posedge CLK); #1;
    check("cas.e3", {hi_bus.Q, lo_bus.Q}, 16'h0101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
